// File: rtl/argmax_pkg.sv
// Shared definitions for the argmax/argmin selector: FSM encoding and compare modes.
package argmax_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMP_GT = 2'd0,
        CMP_GE = 2'd1,
        CMP_LT = 2'd2,
        CMP_LE = 2'd3
    } cmp_mode_t;

    function automatic cmp_mode_t cmp_mode_of(input bit sel_min, input bit tie_last);
        cmp_mode_t mode;
        case ({sel_min, tie_last})
            2'b00:   mode = CMP_GT;
            2'b01:   mode = CMP_GE;
            2'b10:   mode = CMP_LT;
            default: mode = CMP_LE;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/argmax_selector_if.sv
// Element stream and result bundle between the data-source controller and the selector.
interface argmax_selector_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_ELEMS = 4
);
    localparam int IDX_W = $clog2(NUM_ELEMS);

    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] ext_value;
    logic [IDX_W-1:0]  ext_index;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, busy, done, ext_value, ext_index
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, busy, done, ext_value, ext_index
    );

endinterface

// File: rtl/argmax_cmp.sv
// Combinational extreme-value comparator; take_new says whether candidate a displaces incumbent b.
module argmax_cmp
    import argmax_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter bit SEL_MIN  = 1'b0,
    parameter bit TIE_LAST = 1'b0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              take_new
);

    localparam cmp_mode_t MODE = cmp_mode_of(SEL_MIN, TIE_LAST);

    always_comb begin
        take_new = 1'b0;
        case (MODE)
            CMP_GT: take_new = (a >  b);
            CMP_GE: take_new = (a >= b);
            CMP_LT: take_new = (a <  b);
            CMP_LE: take_new = (a <= b);
        endcase
    end

endmodule

// File: rtl/argmax_selector.sv
// Sequential argmax/argmin over NUM_ELEMS words, one per accept; result reported with a done pulse.
//  state | meaning
//  IDLE  | waiting for start; previous result held
//  SCAN  | accepting elements, tracking running extreme
//  DONE  | one-cycle done pulse, result final
module argmax_selector
    import argmax_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_ELEMS = 4,
    parameter bit SEL_MIN   = 1'b0,
    parameter bit TIE_LAST  = 1'b0,
    localparam int IDX_W    = $clog2(NUM_ELEMS)
) (
    input  logic                 clk,
    input  logic                 rst,
    argmax_selector_if.slave     bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  cnt_q;
    logic [DATA_W-1:0] ext_value_q;
    logic [IDX_W-1:0]  ext_index_q;
    logic              accept;
    logic              last_accept;
    logic              take_new;

    assign accept      = (state_q == SCAN) && bus.in_valid;
    assign last_accept = accept && (cnt_q == LAST_IDX);

    argmax_cmp #(
        .DATA_W   (DATA_W),
        .SEL_MIN  (SEL_MIN),
        .TIE_LAST (TIE_LAST)
    ) u_cmp (
        .a        (bus.in_data),
        .b        (ext_value_q),
        .take_new (take_new)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake/status outputs decode from state_q only, so no input-to-output path exists.
    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
                if (last_accept) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The first element of a scan seeds the incumbent regardless of the compare result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            ext_value_q <= '0;
            ext_index_q <= '0;
        end else begin
            if ((state_q == IDLE) && bus.start) begin
                cnt_q <= '0;
            end
            if (accept) begin
                if ((cnt_q == '0) || take_new) begin
                    ext_value_q <= bus.in_data;
                    ext_index_q <= cnt_q;
                end
                cnt_q <= last_accept ? '0 : cnt_q + 1'b1;
            end
        end
    end

    assign bus.ext_value = ext_value_q;
    assign bus.ext_index = ext_index_q;

endmodule

// File: tb/tb_argmax_selector.sv
// Directed bench: four 8-bit/4-element variants share one stream; a 4-bit/5-element variant runs alone.
module tb_argmax_selector;

    logic clk;
    logic rst;

    logic       start;
    logic       in_valid;
    logic [7:0] in_data;

    logic       start4;
    logic       valid4;
    logic [3:0] data4;

    int total_cnt = 0;
    int pass_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    argmax_selector_if #(.DATA_W(8), .NUM_ELEMS(4)) if0 ();
    argmax_selector_if #(.DATA_W(8), .NUM_ELEMS(4)) if1 ();
    argmax_selector_if #(.DATA_W(8), .NUM_ELEMS(4)) if2 ();
    argmax_selector_if #(.DATA_W(8), .NUM_ELEMS(4)) if3 ();
    argmax_selector_if #(.DATA_W(4), .NUM_ELEMS(5)) if4 ();

    assign if0.start = start;  assign if0.in_valid = in_valid;  assign if0.in_data = in_data;
    assign if1.start = start;  assign if1.in_valid = in_valid;  assign if1.in_data = in_data;
    assign if2.start = start;  assign if2.in_valid = in_valid;  assign if2.in_data = in_data;
    assign if3.start = start;  assign if3.in_valid = in_valid;  assign if3.in_data = in_data;
    assign if4.start = start4; assign if4.in_valid = valid4;    assign if4.in_data = data4;

    argmax_selector #(.DATA_W(8), .NUM_ELEMS(4), .SEL_MIN(1'b0), .TIE_LAST(1'b0))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    argmax_selector #(.DATA_W(8), .NUM_ELEMS(4), .SEL_MIN(1'b0), .TIE_LAST(1'b1))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    argmax_selector #(.DATA_W(8), .NUM_ELEMS(4), .SEL_MIN(1'b1), .TIE_LAST(1'b0))
        u2 (.clk(clk), .rst(rst), .bus(if2));
    argmax_selector #(.DATA_W(8), .NUM_ELEMS(4), .SEL_MIN(1'b1), .TIE_LAST(1'b1))
        u3 (.clk(clk), .rst(rst), .bus(if3));
    argmax_selector #(.DATA_W(4), .NUM_ELEMS(5), .SEL_MIN(1'b0), .TIE_LAST(1'b0))
        u4 (.clk(clk), .rst(rst), .bus(if4));

    logic [7:0] act_v [4];
    logic [1:0] act_i [4];
    assign act_v[0] = if0.ext_value; assign act_i[0] = if0.ext_index;
    assign act_v[1] = if1.ext_value; assign act_i[1] = if1.ext_index;
    assign act_v[2] = if2.ext_value; assign act_i[2] = if2.ext_index;
    assign act_v[3] = if3.ext_value; assign act_i[3] = if3.ext_index;

    // ev/ei indexed by variant: 0 max-first, 1 max-last, 2 min-first, 3 min-last
    typedef struct {
        logic [3:0][7:0] d;
        int              gap;
        logic [3:0][7:0] ev;
        logic [3:0][1:0] ei;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [3:0][7:0] pk(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] e);
        return {e, c, b, a};
    endfunction

    function automatic logic [3:0][1:0] pi(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] c, input logic [1:0] e);
        return {e, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Called just after a rising edge; returns at the falling edge after the DONE cycle.
    task automatic run_scan(input logic [3:0][7:0] d, input int gap);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = d[i];
            @(posedge clk); #1 in_valid = 1'b0;
            if (i < 3) repeat (gap) begin @(posedge clk); #1; end
        end
        @(negedge clk);
        chk("done_after_last_accept", if0.done, 1);
        chk("busy_in_done", if3.busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_one_cycle", if0.done, 0);
        chk("idle_after_done", if1.busy, 0);
    endtask

    initial begin
        vecs[0] = '{d: pk(3, 9, 9, 2),       gap: 0, ev: pk(9, 9, 2, 2),       ei: pi(1, 2, 3, 3)};
        vecs[1] = '{d: pk(5, 1, 7, 1),       gap: 0, ev: pk(7, 7, 1, 1),       ei: pi(2, 2, 1, 3)};
        vecs[2] = '{d: pk(4, 8, 6, 1),       gap: 3, ev: pk(8, 8, 1, 1),       ei: pi(1, 1, 3, 3)};
        vecs[3] = '{d: pk(6, 6, 6, 6),       gap: 0, ev: pk(6, 6, 6, 6),       ei: pi(0, 3, 0, 3)};
        vecs[4] = '{d: pk(0, 255, 0, 255),   gap: 0, ev: pk(255, 255, 0, 0),   ei: pi(1, 3, 0, 2)};
        vecs[5] = '{d: pk(255, 0, 128, 254), gap: 0, ev: pk(255, 255, 0, 0),   ei: pi(0, 0, 1, 1)};
        vecs[6] = '{d: pk(10, 20, 30, 40),   gap: 1, ev: pk(40, 40, 10, 10),   ei: pi(3, 3, 0, 0)};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        start4 = 1'b0; valid4 = 1'b0; data4 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ext_value", if0.ext_value, 0);
        chk("reset_ext_index", if0.ext_index, 0);
        chk("reset_in_ready", if0.in_ready, 0);
        chk("reset_busy", if0.busy, 0);
        chk("reset_done", if4.done, 0);

        // Latency: start edge plus four back-to-back accepts puts done in the fifth cycle.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; in_data = 8'd3;
        @(negedge clk);
        chk("scan_in_ready", if0.in_ready, 1);
        @(posedge clk); #1 in_data = 8'd9;
        @(posedge clk); #1 in_data = 8'd9;
        @(posedge clk); #1 in_data = 8'd2;
        @(negedge clk);
        chk("no_done_before_last", if0.done, 0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("latency_done", if0.done, 1);
        chk("latency_value", if0.ext_value, 9);
        chk("latency_index", if0.ext_index, 1);
        @(posedge clk); #1;

        for (int r = 0; r < 7; r++) begin
            run_scan(vecs[r].d, vecs[r].gap);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("vec%0d_cfg%0d_value", r, k), act_v[k], vecs[r].ev[k]);
                chk($sformatf("vec%0d_cfg%0d_index", r, k), act_i[k], vecs[r].ei[k]);
            end
            @(posedge clk); #1;
        end

        // Results hold across idle cycles and into a new scan until its first accept.
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("hold_idle_value", if0.ext_value, 40);
        chk("hold_idle_index", if2.ext_index, 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("hold_scan_value", if0.ext_value, 40);
        chk("hold_scan_ready", if0.in_ready, 1);

        // Reset after two accepts (7, 200) clears everything.
        @(posedge clk); #1 in_valid = 1'b1; in_data = 8'd7;
        @(posedge clk); #1 in_data = 8'd200;
        @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mid_scan_value", if0.ext_value, 200);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_value", if0.ext_value, 0);
        chk("rst_mid_index", if0.ext_index, 0);
        chk("rst_mid_ready", if0.in_ready, 0);
        chk("rst_mid_busy", if0.busy, 0);
        chk("rst_mid_done", if0.done, 0);
        @(posedge clk); #1;
        run_scan(pk(1, 2, 3, 4), 0);
        chk("post_rst_value", if0.ext_value, 4);
        chk("post_rst_index", if0.ext_index, 3);
        @(posedge clk); #1;

        // Five-element, 4-bit variant: stray in_valid in IDLE, start held through SCAN and DONE.
        valid4 = 1'b1; data4 = 4'd9;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("n5_idle_ready", if4.in_ready, 0);
        chk("n5_idle_busy", if4.busy, 0);
        chk("n5_idle_value", if4.ext_value, 0);
        @(posedge clk); #1 valid4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1 valid4 = 1'b1;
        data4 = 4'd15; @(posedge clk); #1;
        data4 = 4'd0;  @(posedge clk); #1;
        data4 = 4'd15; @(posedge clk); #1;
        data4 = 4'd3;  @(posedge clk); #1;
        data4 = 4'd15; @(posedge clk); #1;
        data4 = 4'd7;
        @(negedge clk);
        chk("n5_done", if4.done, 1);
        @(posedge clk); #1 start4 = 1'b0; valid4 = 1'b0;
        @(negedge clk);
        chk("n5_idle_after_done", if4.busy, 0);
        chk("n5_value", if4.ext_value, 15);
        chk("n5_index", if4.ext_index, 0);

        // A fresh scan must start counting at zero again.
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0; valid4 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            data4 = 4'(i);
            @(posedge clk); #1;
        end
        valid4 = 1'b0;
        @(negedge clk);
        chk("n5_rescan_done", if4.done, 1);
        chk("n5_rescan_value", if4.ext_value, 5);
        chk("n5_rescan_index", if4.ext_index, 4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
